// File: rtl/demux_dispatch_1_to_4_if.sv
// rtl/demux_dispatch_1_to_4_if.sv - handshake bundle for the 1-to-4 dispatch stage
interface demux_dispatch_1_to_4_if #(
    parameter int bits     = 16,
    parameter int cnt_bits = 8
);
    logic [bits-1:0]     in_data;
    logic [1:0]          in_sel;
    logic                in_valid;
    logic                in_ready;
    logic [bits-1:0]     out_data_w;
    logic [bits-1:0]     out_data_x;
    logic [bits-1:0]     out_data_y;
    logic [bits-1:0]     out_data_z;
    logic [3:0]          out_valid;
    logic [3:0]          out_ready;
    logic [cnt_bits-1:0] accepted;

    modport master (
        output in_data, in_sel, in_valid, out_ready,
        input  in_ready, out_data_w, out_data_x, out_data_y, out_data_z,
               out_valid, accepted
    );

    modport slave (
        input  in_data, in_sel, in_valid, out_ready,
        output in_ready, out_data_w, out_data_x, out_data_y, out_data_z,
               out_valid, accepted
    );
endinterface

// File: rtl/demux_dispatch_1_to_4.sv
// rtl/demux_dispatch_1_to_4.sv - registered flow-controlled 1-to-4 dispatch with accepted-word counter
module demux_dispatch_1_to_4 #(
    parameter int bits     = 16,
    parameter int cnt_bits = 8
) (
    input  logic                    clock,
    input  logic                    resetn,
    demux_dispatch_1_to_4_if.slave  bus
);

    logic [3:0]          valid_q;
    logic [3:0]          valid_d;
    logic [bits-1:0]     data_q [4];
    logic [bits-1:0]     data_d [4];
    logic [cnt_bits-1:0] accepted_q;
    logic [cnt_bits-1:0] accepted_d;

    logic [3:0]          chan_free;
    logic                in_ready_c;
    logic                load;

    // A channel draining this cycle counts as free, so a word can replace it without a bubble.
    always_comb begin
        chan_free  = ~valid_q | bus.out_ready;
        in_ready_c = resetn & chan_free[bus.in_sel];
        load       = bus.in_valid & in_ready_c;
        valid_d    = valid_q & ~bus.out_ready;
        data_d     = data_q;
        accepted_d = accepted_q;
        if (load) begin
            valid_d[bus.in_sel] = 1'b1;
            data_d[bus.in_sel]  = bus.in_data;
            accepted_d          = accepted_q + cnt_bits'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            valid_q    <= '0;
            accepted_q <= '0;
            for (int n = 0; n < 4; n++) begin
                data_q[n] <= '0;
            end
        end else begin
            valid_q    <= valid_d;
            accepted_q <= accepted_d;
            for (int n = 0; n < 4; n++) begin
                data_q[n] <= data_d[n];
            end
        end
    end

    assign bus.in_ready   = in_ready_c;
    assign bus.out_valid  = valid_q;
    assign bus.out_data_w = data_q[0];
    assign bus.out_data_x = data_q[1];
    assign bus.out_data_y = data_q[2];
    assign bus.out_data_z = data_q[3];
    assign bus.accepted   = accepted_q;

endmodule

// File: tb/tb_demux_dispatch_1_to_4.sv
// tb/tb_demux_dispatch_1_to_4.sv - self-checking bench for demux_dispatch_1_to_4
module tb_demux_dispatch_1_to_4;

    logic clock;
    logic resetn;
    int   n_checks;
    int   n_fail;

    demux_dispatch_1_to_4_if #(.bits(16), .cnt_bits(8)) bus ();

    demux_dispatch_1_to_4 #(.bits(16), .cnt_bits(8)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running exp finished");
        $fatal(1, "timeout");
    end

    function automatic logic [15:0] data_of(input int n);
        case (n)
            0:       return bus.out_data_w;
            1:       return bus.out_data_x;
            2:       return bus.out_data_y;
            default: return bus.out_data_z;
        endcase
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid  = 1'b0;
        bus.in_sel    = 2'd0;
        bus.in_data   = 16'h0;
        bus.out_ready = 4'hF;
    endtask

    task automatic do_reset();
        idle_inputs();
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        resetn = 1'b0;
        bus.in_sel = 2'd1;
        tick();
        tick();
        @(negedge clock);
        n_checks++;
        if (bus.in_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_in_ready: got %b exp 0", bus.in_ready);
        end
        n_checks++;
        if (bus.out_valid !== 4'b0000) begin
            n_fail++; $display("FAIL reset_out_valid: got %b exp 0000", bus.out_valid);
        end
        n_checks++;
        if (bus.accepted !== 8'd0) begin
            n_fail++; $display("FAIL reset_accepted: got %0d exp 0", bus.accepted);
        end
        for (int n = 0; n < 4; n++) begin
            n_checks++;
            if (data_of(n) !== 16'h0) begin
                n_fail++; $display("FAIL reset_data%0d: got %h exp 0000", n, data_of(n));
            end
        end
        resetn = 1'b1;
        @(negedge clock);
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL post_reset_in_ready: got %b exp 1", bus.in_ready);
        end
    endtask

    task automatic test_single_y();
        do_reset();
        bus.in_data = 16'h1234; bus.in_sel = 2'd2; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        n_checks++;
        if (bus.out_valid !== 4'b0100) begin
            n_fail++; $display("FAIL single_y_valid: got %b exp 0100", bus.out_valid);
        end
        n_checks++;
        if (bus.out_data_y !== 16'h1234) begin
            n_fail++; $display("FAIL single_y_data: got %h exp 1234", bus.out_data_y);
        end
        tick();
        n_checks++;
        if (bus.out_valid !== 4'b0000) begin
            n_fail++; $display("FAIL single_y_drain: got %b exp 0000", bus.out_valid);
        end
        n_checks++;
        if (bus.accepted !== 8'd1) begin
            n_fail++; $display("FAIL single_y_accepted: got %0d exp 1", bus.accepted);
        end
    endtask

    task automatic test_backpressure_w();
        do_reset();
        bus.out_ready = 4'b1110;
        bus.in_data = 16'hAAAA; bus.in_sel = 2'd0; bus.in_valid = 1'b1;
        tick();
        bus.in_data = 16'hBBBB;
        @(negedge clock);
        n_checks++;
        if (bus.in_ready !== 1'b0) begin
            n_fail++; $display("FAIL bp_in_ready_stalled: got %b exp 0", bus.in_ready);
        end
        tick();
        n_checks++;
        if (bus.out_data_w !== 16'hAAAA || bus.out_valid[0] !== 1'b1) begin
            n_fail++; $display("FAIL bp_hold: got %h/%b exp aaaa/1", bus.out_data_w, bus.out_valid[0]);
        end
        n_checks++;
        if (bus.accepted !== 8'd1) begin
            n_fail++; $display("FAIL bp_accepted1: got %0d exp 1", bus.accepted);
        end
        bus.out_ready = 4'b1111;
        @(negedge clock);
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_in_ready_drain: got %b exp 1", bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
        bus.out_ready = 4'b1110;
        n_checks++;
        if (bus.out_data_w !== 16'hBBBB || bus.out_valid[0] !== 1'b1) begin
            n_fail++; $display("FAIL bp_replace: got %h/%b exp bbbb/1", bus.out_data_w, bus.out_valid[0]);
        end
        n_checks++;
        if (bus.accepted !== 8'd2) begin
            n_fail++; $display("FAIL bp_accepted2: got %0d exp 2", bus.accepted);
        end
    endtask

    task automatic test_independent_channels();
        do_reset();
        bus.out_ready = 4'b1110;
        bus.in_data = 16'h5555; bus.in_sel = 2'd0; bus.in_valid = 1'b1;
        tick();
        bus.in_data = 16'h0001; bus.in_sel = 2'd1;
        @(negedge clock);
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL indep_in_ready: got %b exp 1", bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
        n_checks++;
        if (bus.out_valid !== 4'b0011) begin
            n_fail++; $display("FAIL indep_valid: got %b exp 0011", bus.out_valid);
        end
        n_checks++;
        if (bus.out_data_x !== 16'h0001 || bus.out_data_w !== 16'h5555) begin
            n_fail++; $display("FAIL indep_data: got x=%h w=%h exp x=0001 w=5555", bus.out_data_x, bus.out_data_w);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] word;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            word = 16'hC000 + 16'(i * 16'h0111);
            bus.in_data = word; bus.in_sel = 2'd3; bus.in_valid = 1'b1;
            @(negedge clock);
            n_checks++;
            if (bus.in_ready !== 1'b1) begin
                n_fail++; $display("FAIL b2b_in_ready[%0d]: got %b exp 1", i, bus.in_ready);
            end
            tick();
            n_checks++;
            if (bus.out_valid[3] !== 1'b1 || bus.out_data_z !== word) begin
                n_fail++; $display("FAIL b2b_word[%0d]: got %h/%b exp %h/1", i, bus.out_data_z, bus.out_valid[3], word);
            end
        end
        bus.in_valid = 1'b0;
        n_checks++;
        if (bus.accepted !== 8'd4) begin
            n_fail++; $display("FAIL b2b_accepted: got %0d exp 4", bus.accepted);
        end
    endtask

    task automatic test_counter_wrap();
        int bad_ready;
        do_reset();
        bad_ready = 0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 256; i++) begin
            bus.in_sel  = 2'($urandom_range(0, 3));
            bus.in_data = 16'($urandom);
            @(negedge clock);
            if (bus.in_ready !== 1'b1) bad_ready++;
            tick();
        end
        bus.in_valid = 1'b0;
        n_checks++;
        if (bad_ready !== 0) begin
            n_fail++; $display("FAIL wrap_in_ready: got %0d stalls exp 0", bad_ready);
        end
        n_checks++;
        if (bus.accepted !== 8'd0) begin
            n_fail++; $display("FAIL wrap_256: got %0d exp 0", bus.accepted);
        end
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        n_checks++;
        if (bus.accepted !== 8'd1) begin
            n_fail++; $display("FAIL wrap_257: got %0d exp 1", bus.accepted);
        end
    endtask

    task automatic test_reset_mid_transfer();
        do_reset();
        bus.out_ready = 4'b0000;
        bus.in_data = 16'h7777; bus.in_sel = 2'd1; bus.in_valid = 1'b1;
        tick();
        bus.in_data = 16'h8888; bus.in_sel = 2'd2;
        tick();
        bus.in_valid = 1'b0;
        n_checks++;
        if (bus.out_valid !== 4'b0110) begin
            n_fail++; $display("FAIL mid_loaded: got %b exp 0110", bus.out_valid);
        end
        resetn = 1'b0;
        bus.in_sel = 2'd0;
        @(negedge clock);
        n_checks++;
        if (bus.in_ready !== 1'b0) begin
            n_fail++; $display("FAIL mid_in_ready_rst: got %b exp 0", bus.in_ready);
        end
        tick();
        n_checks++;
        if (bus.out_valid !== 4'b0000 || bus.accepted !== 8'd0) begin
            n_fail++; $display("FAIL mid_cleared: got %b/%0d exp 0000/0", bus.out_valid, bus.accepted);
        end
        n_checks++;
        if (bus.out_data_x !== 16'h0 || bus.out_data_y !== 16'h0) begin
            n_fail++; $display("FAIL mid_data: got x=%h y=%h exp 0000", bus.out_data_x, bus.out_data_y);
        end
        resetn = 1'b1;
        @(negedge clock);
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL mid_in_ready_after: got %b exp 1", bus.in_ready);
        end
        tick();
    endtask

    task automatic test_random_traffic();
        logic [15:0] mq [4][$];
        int          acc;
        logic        exp_ready;
        logic        exp_v;
        int          s;
        do_reset();
        acc = 0;
        for (int n = 0; n < 4; n++) mq[n].delete();
        for (int c = 0; c < 400; c++) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.in_sel    = 2'($urandom_range(0, 3));
            bus.in_data   = 16'($urandom);
            bus.out_ready = 4'($urandom);
            @(negedge clock);
            s = int'(bus.in_sel);
            exp_ready = (mq[s].size() == 0) || bus.out_ready[s];
            n_checks++;
            if (bus.in_ready !== exp_ready) begin
                n_fail++; $display("FAIL rand_in_ready c%0d: got %b exp %b", c, bus.in_ready, exp_ready);
            end
            for (int n = 0; n < 4; n++) begin
                exp_v = (mq[n].size() != 0);
                n_checks++;
                if (bus.out_valid[n] !== exp_v) begin
                    n_fail++; $display("FAIL rand_valid c%0d ch%0d: got %b exp %b", c, n, bus.out_valid[n], exp_v);
                end else if (exp_v && data_of(n) !== mq[n][0]) begin
                    n_fail++; $display("FAIL rand_data c%0d ch%0d: got %h exp %h", c, n, data_of(n), mq[n][0]);
                end
            end
            for (int n = 0; n < 4; n++) begin
                if (bus.out_ready[n] && mq[n].size() != 0) void'(mq[n].pop_front());
            end
            if (bus.in_valid && exp_ready) begin
                mq[s].push_back(bus.in_data);
                acc++;
            end
            tick();
        end
        bus.in_valid = 1'b0;
        n_checks++;
        if (bus.accepted !== 8'(acc)) begin
            n_fail++; $display("FAIL rand_accepted: got %0d exp %0d", bus.accepted, acc % 256);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        resetn   = 1'b0;
        idle_inputs();
        test_reset();
        test_single_y();
        test_backpressure_w();
        test_independent_channels();
        test_back_to_back();
        test_counter_wrap();
        test_reset_mid_transfer();
        test_random_traffic();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
